// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter: read-owner encoding,
// last-grant state encoding and the default fetch starvation limit.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    LAST_IDLE   = 2'd0,
    LAST_IFETCH = 2'd1,
    LAST_DREAD  = 2'd2,
    LAST_DWRITE = 2'd3
  } last_e;

  localparam int unsigned MAXWAIT_DEFAULT = 4;
  localparam int unsigned STARVE_W        = 4;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Grant selection for the three requesters: fixed priority store > load >
// fetch, overridden in favour of fetch once it has waited MAXWAIT cycles.
module arb_prio
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAXWAIT = MAXWAIT_DEFAULT
) (
  input  logic clk,
  input  logic resetb,
  input  logic imem_ready,
  input  logic dmem_rready,
  input  logic dmem_wready,
  output logic imem_grant,
  output logic dmem_rgrant,
  output logic dmem_wgrant
);

  localparam logic [STARVE_W-1:0] MAXWAIT_C = STARVE_W'(MAXWAIT);

  logic [STARVE_W-1:0] starve_p1;
  logic                starved;

  assign starved = imem_ready && (starve_p1 == MAXWAIT_C);

  // One-hot grant decision, suppressed entirely while reset is asserted
  always_comb begin
    imem_grant  = 1'b0;
    dmem_rgrant = 1'b0;
    dmem_wgrant = 1'b0;
    if (!resetb) begin
      if (starved)          imem_grant  = 1'b1;
      else if (dmem_wready) dmem_wgrant = 1'b1;
      else if (dmem_rready) dmem_rgrant = 1'b1;
      else if (imem_ready)  imem_grant  = 1'b1;
    end
  end

  // Count consecutive cycles a fetch waits; saturates at MAXWAIT
  always_ff @(posedge clk) begin
    if (resetb) begin
      starve_p1 <= '0;
    end else if (!imem_ready || imem_grant) begin
      starve_p1 <= '0;
    end else if (starve_p1 != MAXWAIT_C) begin
      starve_p1 <= starve_p1 + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch, data load and data
// store. Routes the granted request to memory and steers the one-cycle-late
// read response back to whichever requester owned that read.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAXWAIT = MAXWAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        imem_ready,
  input  logic [31:0] imem_addr,
  output logic        imem_grant,
  output logic        imem_rresp,
  output logic [31:0] imem_rdata,
  input  logic        dmem_rready,
  input  logic [31:0] dmem_raddr,
  output logic        dmem_rgrant,
  output logic        dmem_rresp,
  output logic [31:0] dmem_rdata,
  input  logic        dmem_wready,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_wgrant,
  output logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rresp,
  input  logic [31:0] mem_rdata,
  output last_e       last_grant
);

  owner_e rd_owner_p1;
  last_e  last_p1;
  logic   rsp_ok;

  arb_prio #(
    .MAXWAIT (MAXWAIT)
  ) u_prio (
    .clk         (clk),
    .resetb      (resetb),
    .imem_ready  (imem_ready),
    .dmem_rready (dmem_rready),
    .dmem_wready (dmem_wready),
    .imem_grant  (imem_grant),
    .dmem_rgrant (dmem_rgrant),
    .dmem_wgrant (dmem_wgrant)
  );

  assign mem_ready = imem_grant | dmem_rgrant | dmem_wgrant;
  assign mem_we    = dmem_wgrant;

  // Memory request mux; write payload is zero unless the grant is a store
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (dmem_wgrant) begin
      mem_addr  = dmem_waddr;
      mem_wdata = dmem_wdata;
      mem_wstrb = dmem_wstrb;
    end else if (dmem_rgrant) begin
      mem_addr  = dmem_raddr;
    end else if (imem_grant) begin
      mem_addr  = imem_addr;
    end
  end

  // Stage p1: remember who owns the read returning next cycle, and the grant type
  always_ff @(posedge clk) begin
    if (resetb) begin
      rd_owner_p1 <= OWN_NONE;
      last_p1     <= LAST_IDLE;
    end else begin
      if (imem_grant)       rd_owner_p1 <= OWN_IMEM;
      else if (dmem_rgrant) rd_owner_p1 <= OWN_DMEM;
      else                  rd_owner_p1 <= OWN_NONE;

      if (dmem_wgrant)      last_p1 <= LAST_DWRITE;
      else if (dmem_rgrant) last_p1 <= LAST_DREAD;
      else if (imem_grant)  last_p1 <= LAST_IFETCH;
      else                  last_p1 <= LAST_IDLE;
    end
  end

  assign last_grant = last_p1;
  // A response with no recorded owner (including right after reset) is dropped
  assign rsp_ok     = !resetb && mem_rresp;

  // Response steering to the recorded owner; the other side sees zeros
  always_comb begin
    imem_rresp = 1'b0;
    imem_rdata = '0;
    dmem_rresp = 1'b0;
    dmem_rdata = '0;
    if (!resetb) begin
      if (rd_owner_p1 == OWN_IMEM) begin
        imem_rresp = rsp_ok;
        imem_rdata = mem_rdata;
      end else if (rd_owner_p1 == OWN_DMEM) begin
        dmem_rresp = rsp_ok;
        dmem_rdata = mem_rdata;
      end
    end
  end

endmodule
